// File: rtl/bus_pkg.sv
// Shared definitions for the Wishbone bus decoder: FSM state encoding,
// address-region layout and the default error read data.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } bus_state_e;

    // Address bit 31 splits main memory (0) from the peripheral space (1).
    localparam int PERIPH_BIT    = 31;
    // Inside the peripheral space, bits [30:28] pick the peripheral.
    localparam int PERIPH_SEL_HI = 30;
    localparam int PERIPH_SEL_LO = 28;

    // Wide enough for index 0..8 (memory plus eight peripheral selects).
    localparam int IDX_W = 4;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    // Slave index for an address: 0 for memory, 1+sel for peripherals.
    // The caller decides whether the index is actually populated.
    function automatic logic [IDX_W-1:0] decode_index(input logic [31:0] addr);
        if (addr[PERIPH_BIT]) begin
            return IDX_W'(addr[PERIPH_SEL_HI:PERIPH_SEL_LO]) + IDX_W'(1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Cycle counter bounding how long a slave may hold off its ack.
// expire_o is high on the last permitted wait cycle; the count saturates
// rather than wrapping so a stuck enable can never re-arm it.
module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up while enabled until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/wb_bus_decoder.sv
// Single-master Wishbone-classic decoder. A request is registered in IDLE,
// routed to one slave while in WAIT, and answered with a one-cycle ack in
// RESP. Unmapped addresses and slaves that never ack get an error ack so
// the master is never left hanging.
// Handshake: the master request is m_cyc_i & m_stb_i, sampled only in IDLE;
// a slave completes by raising its s_ack_i bit while its s_cyc_o bit is
// high; m_ack_o is a single-cycle pulse and m_data_o/bus_err_o are valid
// with it. Dropping m_cyc_i during WAIT abandons the access without ack.
module wb_bus_decoder
    import bus_pkg::*;
#(
    parameter int          NUM_SLAVES     = 4,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     m_cyc_i,
    input  logic                     m_stb_i,
    input  logic                     m_we_i,
    input  logic [31:0]              m_addr_i,
    input  logic [31:0]              m_data_i,
    output logic                     m_ack_o,
    output logic [31:0]              m_data_o,
    output logic                     bus_err_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    output logic                     s_we_o,
    output logic [31:0]              s_addr_o,
    output logic [31:0]              s_data_o,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    input  logic [NUM_SLAVES*32-1:0] s_data_i
);

    bus_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;

    logic                  req;
    logic [IDX_W-1:0]      req_idx;
    logic                  req_mapped;
    logic [NUM_SLAVES-1:0] sel;
    logic                  sel_ack;
    logic [31:0]           sel_data;
    logic                  cnt_clear;
    logic                  cnt_enable;
    logic                  expire;

    assign req        = m_cyc_i & m_stb_i;
    assign req_idx    = decode_index(m_addr_i);
    assign req_mapped = (req_idx < IDX_W'(NUM_SLAVES));

    // One-hot select of the latched slave plus its ack and read-data lane.
    always_comb begin
        sel      = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            sel[k]   = (idx_q == IDX_W'(k));
            sel_data = sel_data | ({32{sel[k]}} & s_data_i[k*32 +: 32]);
        end
        sel_ack = |(s_ack_i & sel);
    end

    assign cnt_clear  = (state_q == ST_IDLE) && req;
    assign cnt_enable = (state_q == ST_WAIT);

    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (cnt_clear),
        .enable_i (cnt_enable),
        .expire_o (expire)
    );

    // Next state and datapath: latch the request, then complete on ack,
    // timeout or master abort. A real ack beats a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = m_we_i;
                    addr_d  = m_addr_i;
                    wdata_d = m_data_i;
                    idx_d   = req_idx;
                    if (req_mapped) begin
                        err_d   = 1'b0;
                        state_d = ST_WAIT;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = ERR_DATA;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (!m_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    rdata_d = sel_data;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (expire) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign s_cyc_o   = (state_q == ST_WAIT) ? sel : '0;
    assign s_stb_o   = s_cyc_o;
    assign s_we_o    = we_q;
    assign s_addr_o  = addr_q;
    assign s_data_o  = wdata_q;
    assign m_ack_o   = (state_q == ST_RESP);
    assign bus_err_o = (state_q == ST_RESP) && err_q;
    assign m_data_o  = rdata_q;

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Directed and randomized bench for wb_bus_decoder (4 slaves, 8-cycle
// timeout). Expectations come from the address map and latency rules:
// which slave is hit, in which cycle the ack must appear, and what data
// and error flag it carries.
module tb_wb_bus_decoder;

    localparam int NS = 4;
    localparam int T  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              m_cyc_i, m_stb_i, m_we_i;
    logic [31:0]       m_addr_i, m_data_i;
    logic              m_ack_o, bus_err_o;
    logic [31:0]       m_data_o;
    logic [NS-1:0]     s_cyc_o, s_stb_o;
    logic              s_we_o;
    logic [31:0]       s_addr_o, s_data_o;
    logic [NS-1:0]     s_ack_i;
    logic [NS*32-1:0]  s_data_i;

    int n_asserts = 0;
    int n_fail    = 0;
    bit prev_resp = 0;

    wb_bus_decoder #(
        .NUM_SLAVES     (NS),
        .TIMEOUT_CYCLES (T),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_addr_i  (m_addr_i),
        .m_data_i  (m_data_i),
        .m_ack_o   (m_ack_o),
        .m_data_o  (m_data_o),
        .bus_err_o (bus_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_ack_i   (s_ack_i),
        .s_data_i  (s_data_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Random lane data and random acks on every slave except the target,
    // whose lane and ack are controlled. tgt < 0 means no target.
    task automatic drive_bg(input int tgt, input bit tgt_ack, input logic [31:0] tgt_data);
        for (int k = 0; k < NS; k++) begin
            if (k == tgt) begin
                s_data_i[k*32 +: 32] = tgt_data;
                s_ack_i[k]           = tgt_ack;
            end else begin
                s_data_i[k*32 +: 32] = $urandom;
                s_ack_i[k]           = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " m_ack"},  m_ack_o,   0);
        check({tag, " berr"},   bus_err_o, 0);
        check({tag, " s_cyc"},  s_cyc_o,   0);
        check({tag, " s_stb"},  s_stb_o,   0);
        check({tag, " s_we"},   s_we_o,    0);
        check({tag, " s_addr"}, s_addr_o,  0);
        check({tag, " s_data"}, s_data_o,  0);
        check({tag, " m_data"}, m_data_o,  0);
    endtask

    // One master access. ack_after = number of WAIT cycles before the target
    // acks (1 = first WAIT cycle); 0 or > T means it never acks.
    // Called at a negedge; returns at the negedge where the ack was seen.
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_after, input logic [31:0] sdata, input string tag);
        int          idx;
        bit          mapped;
        int          s;
        int          ack_cyc;
        bit          exp_err;
        logic [31:0] exp_data;
        logic [NS-1:0] exp_cyc;
        bit          acks;
        idx     = addr[31] ? 1 + int'(addr[30:28]) : 0;
        mapped  = (idx < NS);
        s       = prev_resp ? 2 : 1;
        acks    = (ack_after >= 1) && (ack_after <= T);
        if (!mapped) begin
            ack_cyc = s;
            exp_err = 1;
        end else if (acks) begin
            ack_cyc = s + ack_after;
            exp_err = 0;
        end else begin
            ack_cyc = s + T;
            exp_err = 1;
        end
        exp_data = exp_err ? 32'hDEAD_BEEF : sdata;
        m_cyc_i  = 1'b1;
        m_stb_i  = 1'b1;
        m_we_i   = we;
        m_addr_i = addr;
        m_data_i = wdata;
        drive_bg(mapped ? idx : -1, 1'b0, sdata);
        for (int c = 1; c <= ack_cyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_cyc = (mapped && c >= s && c < ack_cyc) ? NS'(1 << idx) : '0;
            check({tag, " s_cyc"}, s_cyc_o, exp_cyc);
            check({tag, " s_stb"}, s_stb_o, exp_cyc);
            check({tag, " m_ack"}, m_ack_o, (c == ack_cyc));
            check({tag, " berr"},  bus_err_o, (c == ack_cyc) && exp_err);
            if (c == s && mapped) begin
                check({tag, " s_we"},   s_we_o,   we);
                check({tag, " s_addr"}, s_addr_o, addr);
                check({tag, " s_data"}, s_data_o, wdata);
            end
            if (c == ack_cyc && (!we || exp_err)) begin
                check({tag, " m_data"}, m_data_o, exp_data);
            end
            if (c == ack_cyc) begin
                m_cyc_i = 1'b0;
                m_stb_i = 1'b0;
            end
            drive_bg(mapped ? idx : -1, mapped && acks && (c == s + ack_after - 1), sdata);
        end
        prev_resp = 1;
    endtask

    // Master gives up after k WAIT cycles (1 <= k < T); no ack may follow.
    task automatic access_abort(input logic [31:0] addr, input int k, input string tag);
        int idx;
        int s;
        logic [NS-1:0] exp_cyc;
        idx      = addr[31] ? 1 + int'(addr[30:28]) : 0;
        s        = prev_resp ? 2 : 1;
        m_cyc_i  = 1'b1;
        m_stb_i  = 1'b1;
        m_we_i   = 1'b0;
        m_addr_i = addr;
        m_data_i = $urandom;
        drive_bg(idx, 1'b0, 32'h0BAD_0BAD);
        for (int c = 1; c <= s + k + 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_cyc = (c >= s && c < s + k) ? NS'(1 << idx) : '0;
            check({tag, " s_cyc"}, s_cyc_o, exp_cyc);
            check({tag, " m_ack"}, m_ack_o, 0);
            if (c == s + k - 1) begin
                m_cyc_i = 1'b0;
                m_stb_i = 1'b0;
            end
            drive_bg(idx, 1'b0, 32'h0BAD_0BAD);
        end
        prev_resp = 0;
    endtask

    task automatic idle(input int n);
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle m_ack", m_ack_o, 0);
            check("idle s_cyc", s_cyc_o, 0);
        end
        prev_resp = 0;
    endtask

    initial begin
        logic [31:0] addr;
        int          r;
        rst_n    = 1'b0;
        m_cyc_i  = 1'b0;
        m_stb_i  = 1'b0;
        m_we_i   = 1'b0;
        m_addr_i = '0;
        m_data_i = '0;
        s_ack_i  = '0;
        s_data_i = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        access(0, 32'h0000_0040, 32'h0, 2, 32'h1234_5678, "rd_mem");
        idle(1);
        access(1, 32'h9000_0004, 32'hA5A5_A5A5, 1, $urandom, "wr_p2");
        access(0, 32'hF000_0000, 32'h0, 1, $urandom, "unmapped");
        access(0, 32'h8000_0000, 32'h0, 0, $urandom, "timeout");
        access(0, 32'h8000_0010, 32'h0, T, 32'hCAFE_F00D, "ack_on_expire");
        access_abort(32'hA000_0000, 3, "abort");
        access(0, 32'h0000_0100, 32'h0, 1, 32'h1111_1111, "b2b_s0");
        access(0, 32'hA000_0008, 32'h0, 3, 32'h2222_2222, "b2b_s2");

        // Reset while a slave is being waited on.
        idle(1);
        m_cyc_i  = 1'b1;
        m_stb_i  = 1'b1;
        m_we_i   = 1'b1;
        m_addr_i = 32'h8000_0020;
        m_data_i = 32'h5555_AAAA;
        drive_bg(1, 1'b0, 32'h0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_mid s_cyc before", s_cyc_o, 4'b0010);
        rst_n   = 1'b0;
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_mid");
        rst_n     = 1'b1;
        prev_resp = 0;

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 2);
            addr = $urandom;
            if (r == 0) begin
                addr[31] = 1'b0;
            end else if (r == 1) begin
                addr[31]    = 1'b1;
                addr[30:28] = 3'($urandom_range(0, NS - 2));
            end else begin
                addr[31] = 1'b1;
            end
            access(1'($urandom_range(0, 1)), addr, $urandom,
                   $urandom_range(0, T + 2), $urandom, "rand");
            if ($urandom_range(0, 3) == 0) begin
                idle($urandom_range(1, 2));
            end
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
